// File: rtl/hot_addr_query_if.sv
// rtl/hot_addr_query_if.sv - handshake bundle between hot_addr_query and its sketch, rate controller and migration consumer
//
// Signals:
//   upd_en / upd_addr / upd_cnt           sketch estimate stream into the table
//   query_en / query_ready                drain request from the rate controller
//   mig_addr_en / mig_addr / mig_addr_ready   hot-address stream to the migration engine
//   upd_drop_cnt                          saturating count of estimates ignored while busy
// Modports: slave = hot_addr_query side, master = the side driving updates/queries.

interface hot_addr_query_if #(
    parameter int ADDR_SIZE = 28,
    parameter int CNT_SIZE  = 13
);
    logic                 upd_en;
    logic [ADDR_SIZE-1:0] upd_addr;
    logic [CNT_SIZE-1:0]  upd_cnt;
    logic                 query_en;
    logic                 query_ready;
    logic                 mig_addr_en;
    logic [ADDR_SIZE-1:0] mig_addr;
    logic                 mig_addr_ready;
    logic [15:0]          upd_drop_cnt;

    modport slave (
        input  upd_en, upd_addr, upd_cnt, query_en, mig_addr_ready,
        output query_ready, mig_addr_en, mig_addr, upd_drop_cnt
    );

    modport master (
        output upd_en, upd_addr, upd_cnt, query_en, mig_addr_ready,
        input  query_ready, mig_addr_en, mig_addr, upd_drop_cnt
    );
endinterface

// File: rtl/hot_addr_query.sv
// rtl/hot_addr_query.sv - top-K hot cache-line table fed by a count sketch and drained on query
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   hot_addr_query_if.slave: update stream, query handshake, migration stream, drop counter
// Parameters: ADDR_SIZE (line address width), CNT_SIZE (count width), TOP_K (entries, 1..16).
// Build option: define HOT_ADDR_QUERY_AGING_EN to halve counts at FLUSH instead of clearing the table.

module hot_addr_query #(
    parameter int ADDR_SIZE = 28,
    parameter int CNT_SIZE  = 13,
    parameter int TOP_K     = 5
) (
    input  logic             clk,
    input  logic             rst,
    hot_addr_query_if.slave  bus
);

    localparam int IW = (TOP_K > 1) ? $clog2(TOP_K) : 1;
    localparam int PW = $clog2(TOP_K + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [15:0]   drop_q, drop_d;

    logic                 valid_q [TOP_K];
    logic [ADDR_SIZE-1:0] addr_q  [TOP_K];
    logic [CNT_SIZE-1:0]  cnt_q   [TOP_K];
    logic                 valid_d [TOP_K];
    logic [ADDR_SIZE-1:0] addr_d  [TOP_K];
    logic [CNT_SIZE-1:0]  cnt_d   [TOP_K];

    // table with the removed entry squeezed out, and table after the insert
    logic                 base_v [TOP_K];
    logic [ADDR_SIZE-1:0] base_a [TOP_K];
    logic [CNT_SIZE-1:0]  base_c [TOP_K];
    logic                 upd_v  [TOP_K];
    logic [ADDR_SIZE-1:0] upd_a  [TOP_K];
    logic [CNT_SIZE-1:0]  upd_c  [TOP_K];

    logic                hit;
    logic [IW-1:0]       hit_idx;
    logic                repl;
    logic                rem_en;
    logic [IW-1:0]       rem_idx;
    logic                ins_en;
    logic [PW-1:0]       ins_pos;
    logic [CNT_SIZE-1:0] new_cnt;
    logic                query_ready_w;
    logic                last_beat;

    assign query_ready_w    = (state_q == IDLE) && !rst;
    assign bus.query_ready  = query_ready_w;
    assign bus.mig_addr_en  = (state_q == DRAIN);
    assign bus.mig_addr     = (state_q == DRAIN) ? addr_q[rd_idx_q] : '0;
    assign bus.upd_drop_cnt = drop_q;

    // Every update is handled as "remove (optional) then insert (optional)".
    // A hit removes the old copy and re-inserts it with max(old, new); a
    // full-table win removes the minimum tail entry. Invalid entries are kept
    // all-zero so shifting them around never leaks stale data.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < TOP_K; i++) begin
            if (!hit && valid_q[i] && (addr_q[i] == bus.upd_addr)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end

        new_cnt = bus.upd_cnt;
        if (hit && (cnt_q[hit_idx] > bus.upd_cnt)) begin
            new_cnt = cnt_q[hit_idx];
        end

        // strict > so an equal count never evicts the resident minimum
        repl    = !hit && valid_q[TOP_K-1] && (bus.upd_cnt > cnt_q[TOP_K-1]);
        rem_en  = bus.upd_en && (hit || repl);
        rem_idx = hit ? hit_idx : IW'(TOP_K - 1);
        ins_en  = bus.upd_en && (hit || repl || !valid_q[TOP_K-1]);

        for (int i = 0; i < TOP_K - 1; i++) begin
            if (rem_en && (IW'(i) >= rem_idx)) begin
                base_v[i] = valid_q[i+1];
                base_a[i] = addr_q[i+1];
                base_c[i] = cnt_q[i+1];
            end else begin
                base_v[i] = valid_q[i];
                base_a[i] = addr_q[i];
                base_c[i] = cnt_q[i];
            end
        end
        if (rem_en) begin
            base_v[TOP_K-1] = 1'b0;
            base_a[TOP_K-1] = '0;
            base_c[TOP_K-1] = '0;
        end else begin
            base_v[TOP_K-1] = valid_q[TOP_K-1];
            base_a[TOP_K-1] = addr_q[TOP_K-1];
            base_c[TOP_K-1] = cnt_q[TOP_K-1];
        end

        // Insert after every entry with cnt >= new_cnt, so ties keep the
        // resident entries ahead of the newcomer.
        ins_pos = '0;
        for (int i = 0; i < TOP_K; i++) begin
            if (base_v[i] && (base_c[i] >= new_cnt)) begin
                ins_pos = ins_pos + PW'(1);
            end
        end

        for (int i = 0; i < TOP_K; i++) begin
            upd_v[i] = base_v[i];
            upd_a[i] = base_a[i];
            upd_c[i] = base_c[i];
        end
        if (ins_en) begin
            for (int i = 1; i < TOP_K; i++) begin
                if (PW'(i) > ins_pos) begin
                    upd_v[i] = base_v[i-1];
                    upd_a[i] = base_a[i-1];
                    upd_c[i] = base_c[i-1];
                end
            end
            for (int i = 0; i < TOP_K; i++) begin
                if (PW'(i) == ins_pos) begin
                    upd_v[i] = 1'b1;
                    upd_a[i] = bus.upd_addr;
                    upd_c[i] = new_cnt;
                end
            end
        end
    end

    // The drain reads the table in place: the table cannot change in DRAIN,
    // so it doubles as the snapshot taken at query acceptance.
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        drop_d   = drop_q;
        for (int i = 0; i < TOP_K; i++) begin
            valid_d[i] = valid_q[i];
            addr_d[i]  = addr_q[i];
            cnt_d[i]   = cnt_q[i];
        end

        last_beat = (rd_idx_q == IW'(TOP_K - 1)) || !valid_q[rd_idx_q + IW'(1)];

        if (bus.upd_en && (state_q != IDLE) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                for (int i = 0; i < TOP_K; i++) begin
                    valid_d[i] = upd_v[i];
                    addr_d[i]  = upd_a[i];
                    cnt_d[i]   = upd_c[i];
                end
                // decide on the post-update table so a same-cycle update is
                // part of the drain
                if (bus.query_en && query_ready_w) begin
                    rd_idx_d = '0;
                    state_d  = upd_v[0] ? DRAIN : FLUSH;
                end
            end
            DRAIN: begin
                if (bus.mig_addr_ready) begin
                    if (last_beat) begin
                        state_d = FLUSH;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            FLUSH: begin
                state_d  = IDLE;
                rd_idx_d = '0;
                for (int i = 0; i < TOP_K; i++) begin
`ifdef HOT_ADDR_QUERY_AGING_EN
                    // Halving preserves descending order, so entries that hit
                    // zero form a tail and the table stays contiguous.
                    cnt_d[i] = cnt_q[i] >> 1;
                    if ((cnt_q[i] >> 1) == '0) begin
                        valid_d[i] = 1'b0;
                        addr_d[i]  = '0;
                    end
`else
                    valid_d[i] = 1'b0;
                    addr_d[i]  = '0;
                    cnt_d[i]   = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_idx_q <= '0;
            drop_q   <= '0;
            for (int i = 0; i < TOP_K; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            drop_q   <= drop_d;
            for (int i = 0; i < TOP_K; i++) begin
                valid_q[i] <= valid_d[i];
                addr_q[i]  <= addr_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_hot_addr_query.sv
// tb/tb_hot_addr_query.sv - directed self-checking bench for hot_addr_query

module tb_hot_addr_query;
    localparam int AW = 28;
    localparam int CW = 13;
    localparam int K  = 5;

    localparam logic [AW-1:0] A_A = 28'h00000A0;
    localparam logic [AW-1:0] A_B = 28'h00000B0;
    localparam logic [AW-1:0] A_C = 28'h00000C0;
    localparam logic [AW-1:0] A_D = 28'h00000D0;
    localparam logic [AW-1:0] A_E = 28'h00000E0;
    localparam logic [AW-1:0] A_F = 28'h00000F0;
    localparam logic [AW-1:0] A_G = 28'h0000100;
    localparam logic [AW-1:0] A_H = 28'h0000110;
    localparam logic [AW-1:0] A_X = 28'h0000120;
    localparam logic [AW-1:0] A_Y = 28'h0000130;
    localparam logic [AW-1:0] A_Z = 28'h0000140;
    localparam logic [AW-1:0] A_P = 28'h0000150;
    localparam logic [AW-1:0] A_Q = 28'h0000160;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    logic [AW-1:0] exp_q [$];
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;

    hot_addr_query_if #(.ADDR_SIZE(AW), .CNT_SIZE(CW)) bus ();

    hot_addr_query #(.ADDR_SIZE(AW), .CNT_SIZE(CW), .TOP_K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [AW-1:0] a, input logic [CW-1:0] c);
        bus.upd_en   = 1'b1;
        bus.upd_addr = a;
        bus.upd_cnt  = c;
        tick();
        bus.upd_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic query();
        bus.query_en = 1'b1;
        tick();
        bus.query_en = 1'b0;
    endtask

    // advance while beats are presented, bounded; ends in the FLUSH cycle
    task automatic drain_to_flush(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (bus.mig_addr_en === 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, bus.mig_addr_en, 1'b0);
    endtask

    // scoreboard side: every accepted beat pops the next expected address
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (bus.mig_addr_en === 1'b1 && bus.mig_addr_ready === 1'b1) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '1;
            check("mig_addr_beat", bus.mig_addr, e);
        end
        if (bus.mig_addr_en === 1'b0) check("mig_addr_zero_when_idle", bus.mig_addr, 0);
        if (prev_stall && bus.mig_addr_en === 1'b1) check("mig_addr_hold", bus.mig_addr, prev_addr);
        prev_stall <= (bus.mig_addr_en === 1'b1) && !bus.mig_addr_ready;
        prev_addr  <= bus.mig_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.upd_en = 1'b0;
        bus.upd_addr = '0;
        bus.upd_cnt = '0;
        bus.query_en = 1'b0;
        bus.mig_addr_ready = 1'b1;
        tick();
        tick();
        check("rst_query_ready", bus.query_ready, 0);
        check("rst_mig_en", bus.mig_addr_en, 0);
        check("rst_mig_addr", bus.mig_addr, 0);
        check("rst_drop_cnt", bus.upd_drop_cnt, 0);
        rst = 1'b0;
        #1;
        check("query_ready_after_rst", bus.query_ready, 1);

        // basic sort and drain order
        upd(A_A, 10);
        upd(A_B, 30);
        upd(A_C, 20);
        check("t1_addr0", dut.addr_q[0], A_B);
        check("t1_addr1", dut.addr_q[1], A_C);
        check("t1_cnt2", dut.cnt_q[2], 10);
        exp_q.push_back(A_B);
        exp_q.push_back(A_C);
        exp_q.push_back(A_A);
        query();
        for (int k = 0; k < 3; k++) begin
            check("t1_beat_en", bus.mig_addr_en, 1);
            tick();
        end
        check("t1_flush_en", bus.mig_addr_en, 0);
        check("t1_flush_qr", bus.query_ready, 0);
        tick();
        check("t1_idle_qr", bus.query_ready, 1);
`ifdef HOT_ADDR_QUERY_AGING_EN
        check("t1_post_flush_cnt0", dut.cnt_q[0], 15);
`else
        check("t1_post_flush_empty", dut.valid_q[0], 0);
`endif
        check("t1_queue_empty", exp_q.size(), 0);

        // full table replacement, max-merge, tie order, stall and drops
        do_reset();
        upd(A_D, 50);
        upd(A_E, 40);
        upd(A_F, 30);
        upd(A_G, 20);
        upd(A_H, 7);
        upd(A_X, 7);
        check("t2_equal_rejected", dut.addr_q[4], A_H);
        upd(A_Y, 8);
        check("t2_y_replaces_min", dut.addr_q[4], A_Y);
        check("t2_y_cnt", dut.cnt_q[4], 8);
        upd(A_F, 45);
        upd(A_G, 45);
        upd(A_D, 5);
        check("t2_f_moved", dut.addr_q[1], A_F);
        check("t2_tie_after", dut.addr_q[2], A_G);
        check("t2_max_kept", dut.cnt_q[0], 50);
        exp_q.push_back(A_D);
        exp_q.push_back(A_F);
        exp_q.push_back(A_G);
        exp_q.push_back(A_E);
        exp_q.push_back(A_Y);
        query();
        check("t2_first_beat_en", bus.mig_addr_en, 1);
        tick();
        bus.mig_addr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_stall_en", bus.mig_addr_en, 1);
            check("t2_stall_addr", bus.mig_addr, A_F);
            if (i < 3) begin
                bus.upd_en   = 1'b1;
                bus.upd_addr = A_Z;
                bus.upd_cnt  = 99;
            end else begin
                bus.query_en = 1'b1;
            end
            tick();
            bus.upd_en   = 1'b0;
            bus.query_en = 1'b0;
        end
        bus.mig_addr_ready = 1'b1;
        drain_to_flush("t2_drain_end", 10);
        check("t2_drop_cnt", bus.upd_drop_cnt, 3);
        tick();
        check("t2_queue_empty", exp_q.size(), 0);
`ifdef HOT_ADDR_QUERY_AGING_EN
        check("t2_post_flush_cnt0", dut.cnt_q[0], 25);
`else
        check("t2_post_flush_empty", dut.valid_q[0], 0);
`endif

        // query on an empty table goes straight to FLUSH
        do_reset();
        query();
        check("t3_flush_qr", bus.query_ready, 0);
        check("t3_flush_en", bus.mig_addr_en, 0);
        tick();
        check("t3_idle_qr", bus.query_ready, 1);
        check("t3_idle_en", bus.mig_addr_en, 0);

        // reset during the second beat of a five-entry drain
        do_reset();
        upd(A_A, 50);
        upd(A_B, 40);
        upd(A_C, 30);
        upd(A_D, 20);
        upd(A_E, 10);
        exp_q.push_back(A_A);
        exp_q.push_back(A_B);
        exp_q.push_back(A_C);
        exp_q.push_back(A_D);
        exp_q.push_back(A_E);
        query();
        check("t4_beat1_en", bus.mig_addr_en, 1);
        tick();
        check("t4_beat2_addr", bus.mig_addr, A_B);
        rst = 1'b1;
        tick();
        check("t4_abort_en", bus.mig_addr_en, 0);
        check("t4_abort_addr", bus.mig_addr, 0);
        check("t4_table_empty", dut.valid_q[0], 0);
        check("t4_rst_qr", bus.query_ready, 0);
        check("t4_beats_seen", exp_q.size(), 3);
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("t4_release_qr", bus.query_ready, 1);

        // aging behaviour on counts {9,1}
        do_reset();
        upd(A_P, 9);
        upd(A_Q, 1);
        exp_q.push_back(A_P);
        exp_q.push_back(A_Q);
        query();
        check("t5_beat_en", bus.mig_addr_en, 1);
        drain_to_flush("t5_drain_end", 10);
        tick();
        check("t5_queue_empty", exp_q.size(), 0);
`ifdef HOT_ADDR_QUERY_AGING_EN
        check("t5_entry0_valid", dut.valid_q[0], 1);
        check("t5_entry0_addr", dut.addr_q[0], A_P);
        check("t5_entry0_cnt", dut.cnt_q[0], 4);
        check("t5_entry1_gone", dut.valid_q[1], 0);
`else
        check("t5_entry0_cleared", dut.valid_q[0], 0);
        check("t5_cnt0_cleared", dut.cnt_q[0], 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
